axi_lite_reset_ctrl: RTL and testbench
======================================

# axi_lite_reset_ctrl

AXI4-Lite responder that gives software control over peripheral reset lines in the VLC design. The bus master writes a trigger register, and the block drives one reset output per channel high for a programmable number of clock cycles. Busy status, pulse length and a scratch register can be read back over the same interface. It is the register-file end of the S00_AXI master transactions used across the block designs: 32-bit data, OKAY responses, 4-byte register stride.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; the decode uses addr[3:2].
- N_RST, 4, number of reset outputs, 1..8.
- CNT_W, 16, pulse-length counter width.

Clock and reset are fixed: one clock, and reset is synchronous and active-high.
- s00_axi_aclk  in  1  clock; all logic on the rising edge.
- s00_axi_areset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- rst_out  out  N_RST  per-channel reset pulses, active-high.

## Operation
Register map (addr[3:2]):
- 0x0 TRIG: write-one-to-trigger; reads return 0.
- 0x4 PLEN: read/write; bits [CNT_W-1:0] are the pulse length, upper bits read 0.
  - Reset value is 16.
  - Honours wstrb per byte.
- 0x8 STATUS: read-only; bit i is busy[i]. Writes are ignored.
- 0xC SCRATCH: read/write, 32 bits, honours wstrb, reset value 0.

Trigger behaviour:
- A write to TRIG with wdata[i]=1 and wstrb[0]=1 starts channel i, but only if channel i is idle.
- A trigger on a busy channel is ignored; the pulse is not extended.
- The pulse length is latched at the trigger. A later PLEN write does not affect a pulse already running.
- A PLEN value of 0 is treated as 1.

Channel states, one pair per channel:
- IDLE -> ACTIVE on a trigger; the counter is loaded with max(PLEN,1).
- In ACTIVE the counter decrements each cycle.
- ACTIVE -> IDLE when the counter reaches 1 and decrements.
- rst_out[i] and busy[i] are 1 exactly in ACTIVE.

All responses are OKAY (2'b00) unless RESET_CTRL_SLVERR_EN is defined (see Configuration).

## Timing
Reset values while s00_axi_areset=1, sampled at the edge:
- awready, wready, bvalid, arready, rvalid are 0.
- rdata is 0; bresp and rresp are 0.
- All channels go to IDLE.
- PLEN=16, SCRATCH=0.
- rst_out is forced all-ones (downstream blocks are held in reset). It goes 0 on the first cycle after reset deasserts.

Write channel:
- awready and wready pulse high together for one cycle when awvalid & wvalid & !bvalid & !awready.
- The register update happens on that same edge (T).
- bvalid rises at T+1 and holds until bready. Only one write is outstanding at a time.
- If AW arrives without W (or W without AW), neither is accepted until both are valid.

Read channel:
- arready pulses for one cycle when arvalid & !rvalid & !arready.
- rdata is registered at that edge, and rvalid rises the next cycle.
- rvalid and rdata hold until rready.

Trigger timing:
- A TRIG write accepted at edge T drives rst_out[i] high on cycles T+1 .. T+L, where L is the latched length.
- STATUS reads reflect busy at the cycle arready is high.

Simultaneous events:
- A read and a write may complete in the same cycle. The read returns the pre-write value.
- If reset is asserted mid-pulse, all channels abort to IDLE. rst_out is held all-ones during reset, then reads 0 after.
- A trigger at the same edge as a channel's final count is ignored; the channel must be IDLE at the write edge.

## Configuration
RESET_CTRL_SLVERR_EN:
- Defined: a write to STATUS returns bresp=SLVERR (2'b10). A TRIG write that hits a busy channel also returns SLVERR; idle channels in the same write still start. Reads always return OKAY.
- Undefined: all responses are OKAY, and the SLVERR logic is not generated.

## Structure
- Shared package axi_lite_reset_ctrl_pkg holds:
  - register offsets: ADDR_TRIG=2'd0, ADDR_PLEN=2'd1, ADDR_STATUS=2'd2, ADDR_SCRATCH=2'd3;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - PLEN_RESET=16.
- One sub-module, reset_pulse_gen: a single-channel FSM and counter with inputs trig and len[CNT_W-1:0] and outputs pulse and busy. It is instantiated N_RST times in a generate loop.

## Test plan
- Reset, then read all four registers -> TRIG=0x0, PLEN=0x10, STATUS=0x0, SCRATCH=0x0; rst_out=0 after reset; all rresp=OKAY.
- Write SCRATCH 0xDEAD0011 with wstrb=4'b0101, after first writing 0xFFFFFFFF -> read returns 0xFFADFF11.
- Write PLEN=5, then TRIG=0x1 -> rst_out[0] high for exactly 5 cycles starting one cycle after the write edge; STATUS reads 0x1 mid-pulse and 0x0 afterwards.
- Trigger channel 1 with PLEN=20; at cycle 10 write TRIG=0x2 again and PLEN=3 -> pulse is still exactly 20 cycles and no retrigger occurs; with RESET_CTRL_SLVERR_EN, the second TRIG returns bresp=2'b10.
- Write PLEN=0, then TRIG=0xF -> all four rst_out bits are high for 1 cycle simultaneously.
- Present AW 3 cycles before W while holding bready low for 4 cycles -> accept occurs only when both are valid; bvalid holds until bready; a second write is not accepted while bvalid=1.

Source files
------------

// File: rtl/axi_lite_reset_ctrl_pkg.sv
// Shared constants and types for the AXI4-Lite reset controller.
// Register offsets, response codes, channel state encoding and the byte-enable merge helper.
package axi_lite_reset_ctrl_pkg;

    localparam logic [1:0] ADDR_TRIG    = 2'd0;
    localparam logic [1:0] ADDR_PLEN    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SCRATCH = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned PLEN_RESET = 16;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } chan_state_t;

    // Replace only the bytes of old_val selected by wstrb.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_reset_ctrl_if.sv
// AXI4-Lite S00_AXI bus bundle for the reset controller.
// The master modport drives requests; the slave modport is used by the register file.
interface axi_lite_reset_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   s00_axi_awaddr;
    logic [2:0]          s00_axi_awprot;
    logic                s00_axi_awvalid;
    logic                s00_axi_awready;
    logic [DATA_W-1:0]   s00_axi_wdata;
    logic [DATA_W/8-1:0] s00_axi_wstrb;
    logic                s00_axi_wvalid;
    logic                s00_axi_wready;
    logic [1:0]          s00_axi_bresp;
    logic                s00_axi_bvalid;
    logic                s00_axi_bready;
    logic [ADDR_W-1:0]   s00_axi_araddr;
    logic [2:0]          s00_axi_arprot;
    logic                s00_axi_arvalid;
    logic                s00_axi_arready;
    logic [DATA_W-1:0]   s00_axi_rdata;
    logic [1:0]          s00_axi_rresp;
    logic                s00_axi_rvalid;
    logic                s00_axi_rready;

    modport master (
        output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        input  s00_axi_awready,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        output s00_axi_rready
    );

    modport slave (
        input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        output s00_axi_awready,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        input  s00_axi_rready
    );
endinterface

// File: rtl/reset_pulse_gen.sv
// Single-channel reset pulse generator: IDLE/ACTIVE FSM with a down-counter.
// The pulse output is forced high while rst is asserted so downstream logic stays held.
module reset_pulse_gen
    import axi_lite_reset_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] len,
    output logic             pulse,
    output logic             busy
);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= (state_d == CH_ACTIVE);
        end
    end

    // Triggers are only honoured from IDLE; a zero length still yields one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CH_IDLE: begin
                if (trig) begin
                    state_d = CH_ACTIVE;
                    cnt_d   = (len == '0) ? CNT_W'(1) : len;
                end
            end
            CH_ACTIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = CH_IDLE;
            end
            default: state_d = CH_IDLE;
        endcase
    end

    assign busy = (state_q == CH_ACTIVE);

endmodule

// File: rtl/axi_lite_reset_ctrl.sv
// AXI4-Lite register file driving N_RST software-triggered reset pulses.
// Optional RESET_CTRL_SLVERR_EN: STATUS writes and triggers on busy channels answer SLVERR.
module axi_lite_reset_ctrl
    import axi_lite_reset_ctrl_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned N_RST              = 4,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_areset,
    axi_lite_reset_ctrl_if.slave  s00_axi,
    output logic [N_RST-1:0]      rst_out
);

    localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_c, araddr_c;
    logic [1:0]        waddr_c, raddr_c;
    logic              wr_en_c, rd_en_c;
    logic [N_RST-1:0]  trig_c, busy_vec;
    logic [DATA_W-1:0] rd_data_c;

    logic              awready_q, wready_q, bvalid_q;
    logic              arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  plen_q;
    logic [31:0]       scratch_q;

    assign awaddr_c = s00_axi.s00_axi_awaddr;
    assign araddr_c = s00_axi.s00_axi_araddr;
    assign waddr_c  = awaddr_c[3:2];
    assign raddr_c  = araddr_c[3:2];

    // Accept a write only with AW and W both present and no response pending.
    assign wr_en_c = s00_axi.s00_axi_awvalid & s00_axi.s00_axi_wvalid & ~bvalid_q & ~awready_q;
    assign rd_en_c = s00_axi.s00_axi_arvalid & ~rvalid_q & ~arready_q;

    assign trig_c = (wr_en_c && (waddr_c == ADDR_TRIG) && s00_axi.s00_axi_wstrb[0])
                    ? s00_axi.s00_axi_wdata[N_RST-1:0] : '0;

    always_comb begin
        rd_data_c = '0;
        case (raddr_c)
            ADDR_PLEN:    rd_data_c = DATA_W'(plen_q);
            ADDR_STATUS:  rd_data_c = DATA_W'(busy_vec);
            ADDR_SCRATCH: rd_data_c = DATA_W'(scratch_q);
            default:      rd_data_c = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            plen_q    <= CNT_W'(PLEN_RESET);
            scratch_q <= '0;
        end else begin
            awready_q <= wr_en_c;
            wready_q  <= wr_en_c;
            if (awready_q)                   bvalid_q <= 1'b1;
            else if (s00_axi.s00_axi_bready) bvalid_q <= 1'b0;

            if (wr_en_c) begin
                case (waddr_c)
                    ADDR_PLEN: plen_q <= CNT_W'(apply_wstrb(32'(plen_q),
                                     s00_axi.s00_axi_wdata, s00_axi.s00_axi_wstrb));
                    ADDR_SCRATCH: scratch_q <= apply_wstrb(scratch_q,
                                     s00_axi.s00_axi_wdata, s00_axi.s00_axi_wstrb);
                    default: ;
                endcase
            end

            arready_q <= rd_en_c;
            if (rd_en_c) rdata_q <= rd_data_c;
            if (arready_q)                   rvalid_q <= 1'b1;
            else if (s00_axi.s00_axi_rready) rvalid_q <= 1'b0;
        end
    end

`ifdef RESET_CTRL_SLVERR_EN
    logic       wr_err_c;
    logic [1:0] bresp_q;

    assign wr_err_c = (waddr_c == ADDR_STATUS) || (|(trig_c & busy_vec));

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset)  bresp_q <= RESP_OKAY;
        else if (wr_en_c)    bresp_q <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
    end

    assign s00_axi.s00_axi_bresp = bresp_q;
`else
    assign s00_axi.s00_axi_bresp = RESP_OKAY;
`endif

    for (genvar i = 0; i < N_RST; i++) begin : g_chan
        reset_pulse_gen #(.CNT_W(CNT_W)) u_gen (
            .clk   (s00_axi_aclk),
            .rst   (s00_axi_areset),
            .trig  (trig_c[i]),
            .len   (plen_q),
            .pulse (rst_out[i]),
            .busy  (busy_vec[i])
        );
    end

    assign s00_axi.s00_axi_awready = awready_q;
    assign s00_axi.s00_axi_wready  = wready_q;
    assign s00_axi.s00_axi_bvalid  = bvalid_q;
    assign s00_axi.s00_axi_arready = arready_q;
    assign s00_axi.s00_axi_rvalid  = rvalid_q;
    assign s00_axi.s00_axi_rdata   = rdata_q;
    assign s00_axi.s00_axi_rresp   = RESP_OKAY;

    logic unused_ok_c;
    assign unused_ok_c = &{1'b0, s00_axi.s00_axi_awprot, s00_axi.s00_axi_arprot,
                           awaddr_c[1:0], araddr_c[1:0]};

endmodule

// File: tb/tb_axi_lite_reset_ctrl.sv
// Directed testbench for axi_lite_reset_ctrl (default build, or with RESET_CTRL_SLVERR_EN).
// Expected values are hand-computed constants; a monitor counts per-channel pulse cycles.
module tb_axi_lite_reset_ctrl;
    import axi_lite_reset_ctrl_pkg::*;

    localparam int unsigned N_RST = 4;

    logic             tb_ACLK = 1'b0;
    logic             tb_areset;
    logic [N_RST-1:0] rst_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_rst_rd [4] = '{32'h0, 32'h10, 32'h0, 32'h0};

`ifdef RESET_CTRL_SLVERR_EN
    localparam logic [1:0] EXP_ERR_RESP = 2'b10;
`else
    localparam logic [1:0] EXP_ERR_RESP = 2'b00;
`endif

    axi_lite_reset_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    axi_lite_reset_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .N_RST              (N_RST),
        .CNT_W              (16)
    ) dut (
        .s00_axi_aclk   (tb_ACLK),
        .s00_axi_areset (tb_areset),
        .s00_axi        (bus),
        .rst_out        (rst_out)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    // Pulse monitor: high-cycle and rising-edge counts per channel, plus rst_out right after an accept.
    int               hi_cnt   [N_RST];
    int               rise_cnt [N_RST];
    logic [N_RST-1:0] prev_rst;
    logic [N_RST-1:0] acc_rst;
    logic             mon_clr;

    always @(posedge tb_ACLK) begin
        if (mon_clr) begin
            for (int i = 0; i < N_RST; i++) begin
                hi_cnt[i]   = 0;
                rise_cnt[i] = 0;
            end
            acc_rst = '0;
        end else begin
            for (int i = 0; i < N_RST; i++) begin
                if (rst_out[i]) hi_cnt[i]++;
                if (rst_out[i] && !prev_rst[i]) rise_cnt[i]++;
            end
            if (bus.s00_axi_awready) acc_rst = rst_out;
        end
        prev_rst = rst_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bus.s00_axi_awaddr  = addr;
        bus.s00_axi_wdata   = data;
        bus.s00_axi_wstrb   = strb;
        bus.s00_axi_awvalid = 1'b1;
        bus.s00_axi_wvalid  = 1'b1;
        bus.s00_axi_bready  = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.s00_axi_awready && n < 50);
        if (n >= 50) check("wr_accept_timeout", 32'(bus.s00_axi_awready), 32'd1);
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wvalid  = 1'b0;
        n = 0;
        while (!bus.s00_axi_bvalid && n < 50) begin tick(); n++; end
        if (n >= 50) check("wr_resp_timeout", 32'(bus.s00_axi_bvalid), 32'd1);
        resp = bus.s00_axi_bresp;
        tick();
        bus.s00_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        bus.s00_axi_araddr  = addr;
        bus.s00_axi_arvalid = 1'b1;
        bus.s00_axi_rready  = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!bus.s00_axi_arready && n < 50);
        if (n >= 50) check("rd_accept_timeout", 32'(bus.s00_axi_arready), 32'd1);
        bus.s00_axi_arvalid = 1'b0;
        n = 0;
        while (!bus.s00_axi_rvalid && n < 50) begin tick(); n++; end
        if (n >= 50) check("rd_data_timeout", 32'(bus.s00_axi_rvalid), 32'd1);
        data = bus.s00_axi_rdata;
        resp = bus.s00_axi_rresp;
        bus.s00_axi_rready = 1'b1;
        tick();
        bus.s00_axi_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;

        bus.s00_axi_awaddr  = '0;
        bus.s00_axi_awprot  = '0;
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wdata   = '0;
        bus.s00_axi_wstrb   = '0;
        bus.s00_axi_wvalid  = 1'b0;
        bus.s00_axi_bready  = 1'b0;
        bus.s00_axi_araddr  = '0;
        bus.s00_axi_arprot  = '0;
        bus.s00_axi_arvalid = 1'b0;
        bus.s00_axi_rready  = 1'b0;
        tb_areset = 1'b1;
        mon_clr   = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_out_in_reset", 32'(rst_out), 32'hF);
        check("awready_rst", 32'(bus.s00_axi_awready), 32'd0);
        check("wready_rst",  32'(bus.s00_axi_wready),  32'd0);
        check("bvalid_rst",  32'(bus.s00_axi_bvalid),  32'd0);
        check("arready_rst", 32'(bus.s00_axi_arready), 32'd0);
        check("rvalid_rst",  32'(bus.s00_axi_rvalid),  32'd0);
        tb_areset = 1'b0;
        tick();
        check("rst_out_after_reset", 32'(rst_out), 32'h0);
        mon_clr = 1'b0;

        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rr);
            check($sformatf("reset_read_%0d", i), rd, exp_rst_rd[i]);
            check($sformatf("reset_rresp_%0d", i), 32'(rr), 32'd0);
        end

        // SCRATCH byte enables
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, br);
        check("scratch_fill_bresp", 32'(br), 32'd0);
        axi_write(4'hC, 32'hDEAD_0011, 4'b0101, br);
        axi_read(4'hC, rd, rr);
        check("scratch_wstrb", rd, 32'hFFAD_FF11);

        // PLEN=5 pulse on channel 0
        axi_write(4'h4, 32'd5, 4'hF, br);
        clear_mon();
        axi_write(4'h0, 32'h1, 4'hF, br);
        check("plen5_trig_bresp", 32'(br), 32'd0);
        check("plen5_start", 32'(acc_rst), 32'h1);
        axi_read(4'h8, rd, rr);
        check("plen5_status_mid", rd, 32'h1);
        repeat (10) tick();
        check("plen5_hi_cycles", 32'(hi_cnt[0]), 32'd5);
        check("plen5_rises", 32'(rise_cnt[0]), 32'd1);
        axi_read(4'h8, rd, rr);
        check("plen5_status_after", rd, 32'h0);

        // PLEN=20 on channel 1, retrigger and PLEN change while busy
        axi_write(4'h4, 32'd20, 4'hF, br);
        clear_mon();
        axi_write(4'h0, 32'h2, 4'hF, br);
        repeat (5) tick();
        axi_write(4'h0, 32'h2, 4'hF, br);
        check("retrig_bresp", 32'(br), 32'(EXP_ERR_RESP));
        axi_write(4'h4, 32'd3, 4'hF, br);
        repeat (30) tick();
        check("retrig_hi_cycles", 32'(hi_cnt[1]), 32'd20);
        check("retrig_rises", 32'(rise_cnt[1]), 32'd1);
        check("retrig_ch0_quiet", 32'(hi_cnt[0]), 32'd0);
        axi_read(4'h4, rd, rr);
        check("plen_readback_3", rd, 32'd3);

        // PLEN=0 behaves as 1, all channels together
        axi_write(4'h4, 32'd0, 4'hF, br);
        clear_mon();
        axi_write(4'h0, 32'hF, 4'hF, br);
        check("all_start", 32'(acc_rst), 32'hF);
        repeat (3) tick();
        for (int i = 0; i < N_RST; i++)
            check($sformatf("all_hi_cycles_%0d", i), 32'(hi_cnt[i]), 32'd1);

        // STATUS is read-only
        axi_write(4'h8, 32'hFF, 4'hF, br);
        check("status_wr_bresp", 32'(br), 32'(EXP_ERR_RESP));
        axi_read(4'h8, rd, rr);
        check("status_wr_ignored", rd, 32'h0);

        // AW ahead of W, bready held low, second write blocked by pending response
        bus.s00_axi_bready  = 1'b0;
        bus.s00_axi_awaddr  = 4'hC;
        bus.s00_axi_wdata   = 32'h1234_5678;
        bus.s00_axi_wstrb   = 4'hF;
        bus.s00_axi_awvalid = 1'b1;
        bus.s00_axi_wvalid  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("aw_only_no_accept", 32'(bus.s00_axi_awready), 32'd0);
        end
        bus.s00_axi_wvalid = 1'b1;
        tick();
        check("aw_w_accept", 32'(bus.s00_axi_awready), 32'd1);
        check("aw_w_wready", 32'(bus.s00_axi_wready), 32'd1);
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wvalid  = 1'b0;
        tick();
        check("bvalid_rise", 32'(bus.s00_axi_bvalid), 32'd1);
        bus.s00_axi_wdata   = 32'hCAFE_0001;
        bus.s00_axi_awvalid = 1'b1;
        bus.s00_axi_wvalid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bvalid_hold", 32'(bus.s00_axi_bvalid), 32'd1);
            check("no_second_accept", 32'(bus.s00_axi_awready), 32'd0);
        end
        bus.s00_axi_bready = 1'b1;
        tick();
        check("bvalid_clear", 32'(bus.s00_axi_bvalid), 32'd0);
        check("second_not_yet", 32'(bus.s00_axi_awready), 32'd0);
        tick();
        check("second_accept", 32'(bus.s00_axi_awready), 32'd1);
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wvalid  = 1'b0;
        tick();
        tick();
        bus.s00_axi_bready = 1'b0;
        axi_read(4'hC, rd, rr);
        check("second_write_data", rd, 32'hCAFE_0001);

        // Reset mid-pulse aborts all channels and restores PLEN
        axi_write(4'h4, 32'd20, 4'hF, br);
        axi_write(4'h0, 32'h1, 4'hF, br);
        tick();
        tb_areset = 1'b1;
        tick();
        check("midrst_rst_out", 32'(rst_out), 32'hF);
        tb_areset = 1'b0;
        tick();
        check("midrst_after", 32'(rst_out), 32'h0);
        axi_read(4'h8, rd, rr);
        check("midrst_status", rd, 32'h0);
        axi_read(4'h4, rd, rr);
        check("midrst_plen", rd, 32'h10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
